// File: rtl/client_rr_arbiter.sv
// client_rr_arbiter: round-robin arbiter sharing one downstream resource
// among N clients. The grant is registered and one-hot (or all-zero), and
// it stays with its owner for as long as the owner keeps requesting.
// Optional feature macro: CLIENT_ARB_HOLD_LIMIT_EN. When it is defined, an
// owner that has held the grant for MAX_HOLD consecutive cycles is forced
// to rotate whenever another client is waiting.
module client_rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // Illegal configurations are stopped at elaboration time.
    if (N < 2 || N > 32) begin : g_bad_n
        $error("client_rr_arbiter: N must lie in 2..32");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("client_rr_arbiter: MAX_HOLD must lie in 1..255");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [N-1:0]     grant_r, grant_s;
    logic             grant_valid_r, grant_valid_s;
    logic [IDX_W-1:0] grant_idx_r, grant_idx_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic             all_found_s;
    logic [IDX_W-1:0] all_win_s;
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
    logic [7:0]       hold_cnt_r, hold_cnt_s;
    logic             oth_found_s;
    logic [IDX_W-1:0] oth_win_s;
`endif

    // First set bit of r scanning start, start+1, ... wrapping modulo N.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] rr_search(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] win;
        int               pos;
        found = 1'b0;
        win   = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            pos = (int'(start) + i) % N;
            if (!found && r[pos]) begin
                found = 1'b1;
                win   = IDX_W'(pos);
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    // Index following w, wrapping N-1 back to 0.
    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] w);
        if (int'(w) == N - 1) begin
            return {IDX_W{1'b0}};
        end else begin
            return w + IDX_W'(1'b1);
        end
    endfunction

    // One-hot vector with only bit idx set.
    function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] g;
        for (int i = 0; i < N; i++) begin
            g[i] = (i == int'(idx));
        end
        return g;
    endfunction

    // Next-state and next-output decision for the arbitration FSM.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        grant_idx_s = grant_idx_r;
        ptr_s       = ptr_r;
        {all_found_s, all_win_s} = rr_search(req, ptr_r);
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
        hold_cnt_s  = hold_cnt_r;
        // Candidates for a forced rotation exclude the current owner.
        {oth_found_s, oth_win_s} = rr_search(req & ~grant_r, ptr_r);
`endif
        case (state_r)
            ST_IDLE: begin
                if (all_found_s) begin
                    state_s     = ST_OWNED;
                    grant_s     = to_onehot(all_win_s);
                    grant_idx_s = all_win_s;
                    ptr_s       = next_index(all_win_s);
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
                    hold_cnt_s  = 8'd1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (req[grant_idx_r]) begin
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
                    if (hold_cnt_r < 8'(MAX_HOLD)) begin
                        hold_cnt_s = hold_cnt_r + 8'd1;
                    end else if (oth_found_s) begin
                        grant_s     = to_onehot(oth_win_s);
                        grant_idx_s = oth_win_s;
                        ptr_s       = next_index(oth_win_s);
                        hold_cnt_s  = 8'd1;
                    end else begin
                        // Nobody else waiting: keep the grant, count saturates.
                        hold_cnt_s = 8'(MAX_HOLD);
                    end
`else
                    state_s = ST_OWNED;
`endif
                end else if (all_found_s) begin
                    // Owner released while others wait: hand over with no bubble.
                    grant_s     = to_onehot(all_win_s);
                    grant_idx_s = all_win_s;
                    ptr_s       = next_index(all_win_s);
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
                    hold_cnt_s  = 8'd1;
`endif
                end else begin
                    // Everyone released: go idle, the search pointer is kept.
                    state_s     = ST_IDLE;
                    grant_s     = {N{1'b0}};
                    grant_idx_s = {IDX_W{1'b0}};
                end
            end
            default: begin
                state_s     = ST_IDLE;
                grant_s     = {N{1'b0}};
                grant_idx_s = {IDX_W{1'b0}};
                ptr_s       = {IDX_W{1'b0}};
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
                hold_cnt_s  = 8'd0;
`endif
            end
        endcase
        grant_valid_s = (state_s == ST_OWNED);
    end

    // State and output registers with synchronous reset overriding req.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= {N{1'b0}};
            grant_valid_r <= 1'b0;
            grant_idx_r   <= {IDX_W{1'b0}};
            ptr_r         <= {IDX_W{1'b0}};
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
            hold_cnt_r    <= 8'd0;
`endif
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            grant_valid_r <= grant_valid_s;
            grant_idx_r   <= grant_idx_s;
            ptr_r         <= ptr_s;
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
            hold_cnt_r    <= hold_cnt_s;
`endif
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_idx   = grant_idx_r;

endmodule

// File: tb/tb_client_rr_arbiter.sv
// Self-checking bench for client_rr_arbiter (N=8, MAX_HOLD=4). A reference
// model tracks owner/pointer/hold as plain integers; the expected response
// for every edge is queued and a separate monitor compares it to the DUT.
module tb_client_rr_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
    localparam int IDX_W    = 3;

    logic             clock;
    logic             reset;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    typedef struct packed {
        logic [N-1:0]     g;
        logic [IDX_W-1:0] idx;
        logic             v;
    } exp_t;

    exp_t exp_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   cyc       = 0;

    // Reference model state
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    client_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Round-robin pick: list candidates in priority order, take the first requester.
    function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
        int order[$];
        for (int k = 0; k < N; k++) order.push_back((start + k) % N);
        foreach (order[j]) begin
            if (r[order[j]] && order[j] != excl) return order[j];
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_owner = w;
        m_hold  = 1;
        m_ptr   = (w + 1) % N;
    endtask

    // Advance the model by one clock edge.
    task automatic model_step(input logic [N-1:0] r, input logic rst);
        int w;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            w = pick(r, m_ptr, -1);
            if (w >= 0) take(w);
        end else if (r[m_owner]) begin
`ifdef CLIENT_ARB_HOLD_LIMIT_EN
            if (m_hold < MAX_HOLD) m_hold++;
            else begin
                w = pick(r, m_ptr, m_owner);
                if (w >= 0) take(w);
            end
`endif
        end else begin
            w = pick(r, m_ptr, -1);
            if (w >= 0) take(w);
            else m_owner = -1;
        end
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic drive(input logic [N-1:0] r, input logic rst);
        exp_t e;
        @(negedge clock);
        req   = r;
        reset = rst;
        model_step(r, rst);
        e.v   = (m_owner >= 0);
        e.g   = e.v ? (8'h01 << m_owner) : 8'h00;
        e.idx = e.v ? IDX_W'(m_owner) : 3'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: after each edge, compare DUT outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_cnt++;
                if (grant === e.g && grant_idx === e.idx && grant_valid === e.v) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL grant_check cycle %0d: got grant=%h idx=%0d valid=%b, expected grant=%h idx=%0d valid=%b",
                             cyc, grant, grant_idx, grant_valid, e.g, e.idx, e.v);
                end
                cyc++;
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized sticky requests.
    initial begin
        logic [N-1:0] r;
        req   = 8'h00;
        reset = 1'b1;
        // Reset with everything requesting, then exit reset
        drive(8'hFF, 1'b1);
        drive(8'hFF, 1'b1);
        drive(8'hFF, 1'b0);
        // Lone requester
        drive(8'h00, 1'b1);
        repeat (10) drive(8'h10, 1'b0);
        // Two requesters held
        drive(8'h00, 1'b1);
        repeat (14) drive(8'h06, 1'b0);
        // Release handover with wrap
        drive(8'h00, 1'b1);
        drive(8'h02, 1'b0);
        drive(8'h81, 1'b0);
        drive(8'h01, 1'b0);
        // All release, then wrap past the top
        drive(8'h00, 1'b1);
        drive(8'h20, 1'b0);
        drive(8'h00, 1'b0);
        drive(8'h21, 1'b0);
        // Reset mid-ownership
        drive(8'h00, 1'b1);
        drive(8'h08, 1'b0);
        drive(8'h08, 1'b0);
        drive(8'h0C, 1'b1);
        drive(8'h0C, 1'b0);
        drive(8'h0C, 1'b0);
        // Randomized traffic
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       r = 8'($urandom);
                1:       r = 8'h00;
                2, 3, 4: r[$urandom_range(0, N - 1)] ^= 1'b1;
                default: r = r;
            endcase
            drive(r, ($urandom_range(0, 99) == 0));
        end
        // Let the monitor drain the last expectation
        repeat (3) @(negedge clock);
        check_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
